// File: rtl/rooth_test_monitor.sv
// Pass/fail/timeout monitor for the rooth self-test flow. It snoops the core's
// register-file write port and shadows the test-number, end-flag and result registers.
module rooth_test_monitor #(
  parameter int unsigned CPU_WIDTH      = 32,
  parameter int unsigned CNT_WIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned SETTLE_CYCLES  = 1,
  parameter int unsigned END_REG        = 26,
  parameter int unsigned RESULT_REG     = 27,
  parameter int unsigned TESTNUM_REG    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 rd_we_i,
  input  logic [4:0]           rd_addr_i,
  input  logic [CPU_WIDTH-1:0] rd_data_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic                 fail_o,
  output logic                 timeout_o,
  output logic [CPU_WIDTH-1:0] testnum_o,
  output logic [CNT_WIDTH-1:0] cycles_o
);

  typedef enum logic [1:0] {StIdle, StRun, StSettle, StDone} state_e;

  localparam logic [CNT_WIDTH-1:0] TimeoutLast = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]           SettleInit  = 4'(SETTLE_CYCLES);
  localparam bit                   SettleZero  = (SETTLE_CYCLES == 0);
  localparam logic [4:0]           EndIdx      = 5'(END_REG);
  localparam logic [4:0]           ResultIdx   = 5'(RESULT_REG);
  localparam logic [4:0]           TestnumIdx  = 5'(TESTNUM_REG);
  localparam logic [CPU_WIDTH-1:0] One         = CPU_WIDTH'(1);

  state_e                r_state;
  logic [CPU_WIDTH-1:0]  r_x3, r_x26, r_x27;
  logic [CNT_WIDTH-1:0]  r_cycles;
  logic [3:0]            r_settle_cnt;
  logic                  r_done, r_pass, r_fail, r_timeout;
  logic [CPU_WIDTH-1:0]  r_testnum;

  logic                  w_active, w_snoop;
  logic                  w_wr_end, w_wr_res, w_wr_tnum;
  logic [CPU_WIDTH-1:0]  w_x3_nxt, w_x26_nxt, w_x27_nxt;
  logic                  w_end, w_timeout, w_verdict, w_pass_nxt;

  assign w_active  = (r_state == StRun) || (r_state == StSettle);
  assign w_snoop   = w_active && rd_we_i && (rd_addr_i != 5'd0);
  assign w_wr_end  = w_snoop && (rd_addr_i == EndIdx);
  assign w_wr_res  = w_snoop && (rd_addr_i == ResultIdx);
  assign w_wr_tnum = w_snoop && (rd_addr_i == TestnumIdx);

  assign w_x3_nxt  = w_wr_tnum ? rd_data_i : r_x3;
  assign w_x26_nxt = w_wr_end  ? rd_data_i : r_x26;
  assign w_x27_nxt = w_wr_res  ? rd_data_i : r_x27;

  // Only a RUN-state end write starts the settle window; later ones just update the shadow.
  assign w_end      = (r_state == StRun) && w_wr_end && (w_x26_nxt == One);
  assign w_timeout  = (r_state == StRun) && !w_end && (r_cycles == TimeoutLast);
  assign w_verdict  = (w_end && SettleZero) ||
                      ((r_state == StSettle) && (r_settle_cnt == 4'd1));
  // Verdict sees same-edge writes so a late result still counts.
  assign w_pass_nxt = (w_x27_nxt == One);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StIdle;
      r_x3         <= '0;
      r_x26        <= '0;
      r_x27        <= '0;
      r_cycles     <= '0;
      r_settle_cnt <= '0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_fail       <= 1'b0;
      r_timeout    <= 1'b0;
      r_testnum    <= '0;
    end else if (start_i) begin
      r_state      <= StRun;
      r_x3         <= '0;
      r_x26        <= '0;
      r_x27        <= '0;
      r_cycles     <= '0;
      r_settle_cnt <= '0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_fail       <= 1'b0;
      r_timeout    <= 1'b0;
      r_testnum    <= '0;
    end else begin
      unique case (r_state)
        StRun, StSettle: begin
          r_x3     <= w_x3_nxt;
          r_x26    <= w_x26_nxt;
          r_x27    <= w_x27_nxt;
          r_cycles <= r_cycles + CNT_WIDTH'(1);
          if (w_verdict) begin
            r_state   <= StDone;
            r_done    <= 1'b1;
            r_pass    <= w_pass_nxt;
            r_fail    <= !w_pass_nxt;
            r_testnum <= w_x3_nxt;
          end else if (w_timeout) begin
            r_state   <= StDone;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
            r_testnum <= w_x3_nxt;
          end else if (w_end) begin
            r_state      <= StSettle;
            r_settle_cnt <= SettleInit;
          end else if (r_state == StSettle) begin
            r_settle_cnt <= r_settle_cnt - 4'd1;
          end
        end
        StIdle, StDone: begin
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy_o    = w_active;
  assign done_o    = r_done;
  assign pass_o    = r_pass;
  assign fail_o    = r_fail;
  assign timeout_o = r_timeout;
  assign testnum_o = r_testnum;
  assign cycles_o  = r_cycles;

endmodule

// File: tb/tb_rooth_test_monitor.sv
// Bench for rooth_test_monitor: directed table, hand-written corner sequences and randomized
// runs checked against a run-level model, on three parameterisations sharing one stimulus.
module tb_rooth_test_monitor;

  localparam int N = 110;
  localparam int SET[3] = '{1, 0, 3};
  localparam int TOC[3] = '{100, 100, 40};

  logic        clk, rst, start_i, rd_we_i;
  logic [4:0]  rd_addr_i;
  logic [31:0] rd_data_i;

  logic        busy_w[3], done_w[3], pass_w[3], fail_w[3], tout_w[3];
  logic [31:0] tnum_w[3], cyc_w[3];

  int total = 0;
  int bad   = 0;

  rooth_test_monitor #(.TIMEOUT_CYCLES(100), .SETTLE_CYCLES(1)) u_a (
    .clk(clk), .rst(rst), .start_i(start_i), .rd_we_i(rd_we_i), .rd_addr_i(rd_addr_i),
    .rd_data_i(rd_data_i), .busy_o(busy_w[0]), .done_o(done_w[0]), .pass_o(pass_w[0]),
    .fail_o(fail_w[0]), .timeout_o(tout_w[0]), .testnum_o(tnum_w[0]), .cycles_o(cyc_w[0])
  );
  rooth_test_monitor #(.TIMEOUT_CYCLES(100), .SETTLE_CYCLES(0)) u_b (
    .clk(clk), .rst(rst), .start_i(start_i), .rd_we_i(rd_we_i), .rd_addr_i(rd_addr_i),
    .rd_data_i(rd_data_i), .busy_o(busy_w[1]), .done_o(done_w[1]), .pass_o(pass_w[1]),
    .fail_o(fail_w[1]), .timeout_o(tout_w[1]), .testnum_o(tnum_w[1]), .cycles_o(cyc_w[1])
  );
  rooth_test_monitor #(.TIMEOUT_CYCLES(40), .SETTLE_CYCLES(3)) u_c (
    .clk(clk), .rst(rst), .start_i(start_i), .rd_we_i(rd_we_i), .rd_addr_i(rd_addr_i),
    .rd_data_i(rd_data_i), .busy_o(busy_w[2]), .done_o(done_w[2]), .pass_o(pass_w[2]),
    .fail_o(fail_w[2]), .timeout_o(tout_w[2]), .testnum_o(tnum_w[2]), .cycles_o(cyc_w[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x3;
    logic [31:0] x27;
    int          k;      // RUN cycle (cycles_o value) of the x26=1 write, -1 for none
    logic        e_pass;
    logic        e_fail;
    logic        e_tout;
    logic [31:0] e_tnum;
    logic [31:0] e_cyc;
  } vec_t;

  vec_t tbl[6];

  logic        s_we[N];
  logic [4:0]  s_ad[N];
  logic [31:0] s_dt[N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    rd_we_i = 1'b1; rd_addr_i = a; rd_data_i = d;
  endtask

  task automatic idle();
    rd_we_i = 1'b0; rd_addr_i = '0; rd_data_i = '0;
  endtask

  task automatic do_start();
    idle();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic chk_zero(input string tag, input int d);
    chk({tag, " busy"}, busy_w[d], 0);
    chk({tag, " done"}, done_w[d], 0);
    chk({tag, " pass"}, pass_w[d], 0);
    chk({tag, " fail"}, fail_w[d], 0);
    chk({tag, " tout"}, tout_w[d], 0);
    chk({tag, " tnum"}, tnum_w[d], 0);
    chk({tag, " cyc"},  cyc_w[d],  0);
  endtask

  // Run-level reference: locate the first end write, derive verdict edge and last shadow values.
  task automatic model(input int s, input int to, output int d, output logic pass,
                       output logic tout, output logic [31:0] tnum);
    int k = -1;
    logic [31:0] res = 0;
    tnum = 0;
    for (int j = 0; j < N; j++)
      if (k < 0 && s_we[j] && s_ad[j] == 5'd26 && s_dt[j] == 1) k = j;
    if (k >= 0 && k <= to - 1) begin d = k + 1 + s; tout = 1'b0; end
    else begin d = to; tout = 1'b1; end
    for (int j = 0; j < d; j++) begin
      if (s_we[j] && s_ad[j] == 5'd27) res = s_dt[j];
      if (s_we[j] && s_ad[j] == 5'd3)  tnum = s_dt[j];
    end
    pass = !tout && (res == 1);
  endtask

  initial begin
    int          dd[3];
    logic        mp[3], mt[3];
    logic [31:0] mn[3];
    int          mode, pick;
    string       nm;

    tbl[0] = '{5,  1, 19, 1, 0, 0, 5,  21};
    tbl[1] = '{7,  0, 10, 0, 1, 0, 7,  12};
    tbl[2] = '{9,  1, 98, 1, 0, 0, 9,  100};
    tbl[3] = '{4,  1, -1, 0, 0, 1, 4,  100};
    tbl[4] = '{11, 2, 50, 0, 1, 0, 11, 52};
    tbl[5] = '{12, 1, 99, 1, 0, 0, 12, 101};

    rst = 1'b1; start_i = 1'b0; idle();
    tick(); tick();
    chk_zero("reset", 0);
    rst = 1'b0;
    wr(5'd26, 1); tick(); tick(); idle();
    chk_zero("idle_ignore", 0);

    for (int i = 0; i < 6; i++) begin
      do_start();
      for (int j = 0; j < 105; j++) begin
        if (j == 0) wr(5'd3, tbl[i].x3);
        else if (j == 1) wr(5'd27, tbl[i].x27);
        else if (j == tbl[i].k) wr(5'd26, 1);
        else idle();
        tick();
      end
      idle();
      nm = $sformatf("tbl%0d", i);
      chk({nm, " done"}, done_w[0], 1);
      chk({nm, " busy"}, busy_w[0], 0);
      chk({nm, " pass"}, pass_w[0], tbl[i].e_pass);
      chk({nm, " fail"}, fail_w[0], tbl[i].e_fail);
      chk({nm, " tout"}, tout_w[0], tbl[i].e_tout);
      chk({nm, " tnum"}, tnum_w[0], tbl[i].e_tnum);
      chk({nm, " cyc"},  cyc_w[0],  tbl[i].e_cyc);
    end

    // Late result: x27 arrives during the settle cycle.
    do_start();
    wr(5'd26, 1); tick();
    chk("late busy", busy_w[0], 1);
    chk("late done_early", done_w[0], 0);
    chk("late s0 fail", fail_w[1], 1);
    wr(5'd27, 1); tick(); idle();
    chk("late done", done_w[0], 1);
    chk("late pass", pass_w[0], 1);
    chk("late cyc", cyc_w[0], 2);

    // Zero settle: verdict on the end-write edge.
    do_start();
    wr(5'd27, 1); tick();
    wr(5'd26, 1); tick(); idle();
    chk("s0 done", done_w[1], 1);
    chk("s0 pass", pass_w[1], 1);
    chk("s0 cyc", cyc_w[1], 2);
    chk("s0 other_done", done_w[0], 0);

    // Ignored writes leave the run going.
    do_start();
    wr(5'd0, 1); tick();
    wr(5'd26, 2); tick(); idle(); tick();
    chk("ign busy", busy_w[0], 1);
    chk("ign done", done_w[0], 0);

    // Abort: restart clears counter and shadows.
    wr(5'd3, 6); tick();
    wr(5'd27, 1); tick();
    do_start();
    chk("abort cyc", cyc_w[0], 0);
    chk("abort busy", busy_w[0], 1);
    wr(5'd26, 1); tick(); idle(); tick();
    chk("abort done", done_w[0], 1);
    chk("abort fail", fail_w[0], 1);
    chk("abort tnum", tnum_w[0], 0);

    // Reset mid-settle acts without a clock edge.
    do_start();
    wr(5'd3, 8); tick();
    wr(5'd26, 1); tick(); idle();
    chk("rst pre busy", busy_w[0], 1);
    #2 rst = 1'b1;
    #1 chk_zero("rst_async", 0);
    tick(); rst = 1'b0; tick(); tick();
    chk("rst post done", done_w[0], 0);
    chk("rst post busy", busy_w[0], 0);

    for (int r = 0; r < 24; r++) begin
      mode = r % 3;
      for (int j = 0; j < N; j++) begin
        s_we[j] = ($urandom_range(0, 1) == 1);
        pick = $urandom_range(0, 5);
        case (pick)
          0: begin s_ad[j] = 5'd0;  s_dt[j] = 1; end
          1: begin s_ad[j] = 5'd3;  s_dt[j] = $urandom_range(0, 255); end
          2: begin s_ad[j] = 5'd26; s_dt[j] = $urandom_range(0, 2); end
          3, 4: begin s_ad[j] = 5'd27; s_dt[j] = $urandom_range(0, 2); end
          default: begin s_ad[j] = 5'($urandom_range(1, 31)); s_dt[j] = $urandom_range(0, 2); end
        endcase
        if (s_ad[j] == 5'd26 && s_dt[j] == 1 &&
            (mode == 0 || (mode == 2 && j < 80) || (mode == 1 && j < 5)))
          s_dt[j] = 2;
      end
      for (int d = 0; d < 3; d++) model(SET[d], TOC[d], dd[d], mp[d], mt[d], mn[d]);
      do_start();
      for (int j = 0; j < N; j++) begin
        if (s_we[j]) wr(s_ad[j], s_dt[j]); else idle();
        tick();
        for (int d = 0; d < 3; d++) begin
          nm = $sformatf("rnd%0d d%0d t%0d", r, d, j + 1);
          chk({nm, " done"}, done_w[d], (j + 1 >= dd[d]));
          chk({nm, " busy"}, busy_w[d], (j + 1 < dd[d]));
          chk({nm, " cyc"},  cyc_w[d], (j + 1 < dd[d]) ? j + 1 : dd[d]);
          if (j + 1 < dd[d]) chk({nm, " tnum0"}, tnum_w[d], 0);
          if (j + 1 == dd[d]) begin
            chk({nm, " pass"}, pass_w[d], mp[d]);
            chk({nm, " fail"}, fail_w[d], !mt[d] && !mp[d]);
            chk({nm, " tout"}, tout_w[d], mt[d]);
            chk({nm, " tnum"}, tnum_w[d], mn[d]);
          end
        end
      end
      idle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rooth_test_monitor.md
Name: rooth_test_monitor

Overview:
- Synthesizable pass/fail monitor for the rooth ISA self-test flow; consumes the register-file write port of the rooth core inside rooth_soc.
- Keeps shadow copies of the test-protocol registers:
  - x3: test number.
  - x26: end flag.
  - x27: result.
- Reports PASS, FAIL or TIMEOUT when a test program completes, so regression status works on FPGA and in any simulator without hierarchical probes.

Parameters:
- CPU_WIDTH, 32: register data width.
- CNT_WIDTH, 32: cycle counter width.
- TIMEOUT_CYCLES, 50000: number of RUN cycles before a timeout is declared; legal range 1 to 2^CNT_WIDTH-1.
- SETTLE_CYCLES, 1: cycles between the end-flag write and the verdict; legal range 0 to 15.
- END_REG, 26: end-flag register index.
- RESULT_REG, 27: result register index.
- TESTNUM_REG, 3: test-number register index.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  single-cycle pulse that begins a monitored run.
- rd_we_i  in  1  register-file write enable, snooped from the core.
- rd_addr_i  in  5  register-file write address.
- rd_data_i  in  CPU_WIDTH  register-file write data.
- busy_o  out  1  high in RUN and SETTLE.
- done_o  out  1  verdict valid; level signal.
- pass_o  out  1  test passed; valid while done_o is high.
- fail_o  out  1  test failed (result register != 1).
- timeout_o  out  1  run exceeded TIMEOUT_CYCLES.
- testnum_o  out  CPU_WIDTH  shadow of x[TESTNUM_REG] at the verdict.
- cycles_o  out  CNT_WIDTH  RUN cycles elapsed; frozen at the verdict.

Behaviour:
- Reset (asynchronous assert on rst high):
  - State goes to IDLE.
  - All outputs, shadows and counters go to 0.
  - Deassertion is used synchronously.
- FSM states: IDLE, RUN, SETTLE, DONE.
- IDLE -> RUN on start_i.
- On the start_i edge:
  - Shadows for x3, x26 and x27 clear to 0.
  - cycles_o clears to 0.
  - done_o, pass_o, fail_o and timeout_o clear.
- Snooping in RUN and SETTLE:
  - When rd_we_i=1 and rd_addr_i != 0, and rd_addr_i matches a tracked index, that shadow takes rd_data_i.
  - Writes to x0 are ignored.
  - In IDLE and DONE, writes are ignored.
- RUN:
  - cycles_o increments once per cycle.
  - A write of END_REG with data == 1 moves to SETTLE and loads the settle counter with SETTLE_CYCLES.
  - A write of END_REG with any other value only updates the shadow.
  - If SETTLE_CYCLES = 0, RUN goes directly to DONE on that edge, and the verdict uses the shadow x27 including any same-cycle x27 write.
- Timeout:
  - Fires in RUN when cycles_o == TIMEOUT_CYCLES-1 and no qualifying end write occurs in that cycle.
  - Result: DONE with timeout_o=1, pass_o=0, fail_o=0.
  - If an end write and the timeout condition fall in the same cycle, the end write wins.
- SETTLE:
  - The settle counter decrements each cycle.
  - cycles_o keeps incrementing.
  - x27 and x3 writes are still captured.
  - When the counter reaches 1, the next edge enters DONE.
  - Total: exactly SETTLE_CYCLES edges after the end-write edge.
- Verdict, registered on entry to DONE:
  - pass_o = (shadow x27 == 1).
  - fail_o = !pass_o.
  - testnum_o = shadow x3.
  - done_o = 1.
  - pass_o, fail_o and timeout_o are mutually exclusive, and exactly one is high while done_o is high.
- DONE:
  - Outputs hold until start_i or rst.
  - cycles_o is frozen.
- start_i in RUN or SETTLE aborts the current run and restarts it, exactly as from IDLE. No verdict is produced for the aborted run.
- busy_o is high exactly in RUN and SETTLE.
- testnum_o is 0 outside DONE.
- cycles_o does not wrap: TIMEOUT_CYCLES <= 2^CNT_WIDTH-1 guarantees the timeout fires before the counter wraps.
- Reset mid-run: verdict lost, outputs 0. A new start_i is required.

Test Plan:
- Pass run, SETTLE_CYCLES=1:
  - Stimulus: start_i; write x3=5, x27=1, then x26=1 at RUN cycle 20.
  - Required: done_o=1 and pass_o=1 one edge later; testnum_o=5; cycles_o=21; busy_o=0.
- Fail run:
  - Stimulus: x3=7, x27=0, x26=1.
  - Required: fail_o=1, pass_o=0, testnum_o=7, timeout_o=0.
- Late result:
  - Stimulus: x26=1, then x27=1 in the SETTLE cycle.
  - Required: pass_o=1.
- Same-cycle result, SETTLE_CYCLES=0:
  - Stimulus: x27=1 and x26=1 on consecutive edges.
  - Required: pass_o=1 on the edge of the x26 write.
- Timeout, TIMEOUT_CYCLES=100:
  - Stimulus: no x26 write.
  - Required: done_o=1, timeout_o=1, cycles_o=100.
  - Stimulus: repeat with x26=1 written at cycle 99.
  - Required: pass/fail verdict, timeout_o=0.
- Ignored writes, abort and reset:
  - Stimulus: write x0=1, then x26=2.
  - Required: stays RUN, busy_o=1.
  - Stimulus: start_i mid-run.
  - Required: cycles_o restarts at 0, shadows cleared.
  - Stimulus: rst asserted mid-SETTLE.
  - Required: all outputs 0 immediately, without waiting for a clock edge.
